reg_to_apb: RTL and testbench
=============================

REG_TO_APB -- requirements
Module: reg_to_apb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB/request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; STRB_WIDTH = DATA_WIDTH/8 derived.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, max ACCESS-phase cycles before abort; 0 disables timeout.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_i  input  1  clock, all state updates on rising edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 req_valid_i  input  1  request valid; req_ready_o  output  1  request accepted when both high.
REQ-008 req_addr_i  input  ADDR_WIDTH  address; req_write_i  input  1  1=write, 0=read.
REQ-009 req_wdata_i  input  DATA_WIDTH  write data; req_wstrb_i  input  STRB_WIDTH  byte strobes.
REQ-010 rsp_valid_o  output  1  response valid; rsp_ready_i  input  1  response consumed when both high.
REQ-011 rsp_rdata_o  output  DATA_WIDTH  read data; rsp_error_o  output  1  slave error or timeout.
REQ-012 paddr_o  output  ADDR_WIDTH; pwrite_o  output  1; pwdata_o  output  DATA_WIDTH; pstrb_o  output  STRB_WIDTH; pprot_o  output  3 (constant 3'b000).
REQ-013 psel_o  output  1; penable_o  output  1; prdata_i  input  DATA_WIDTH; pready_i  input  1; pslverr_i  input  1.

Function
REQ-014 SHALL implement FSM with states IDLE, SETUP, ACCESS, RESP; all outputs registered or decoded from state only (no combinational path input->output).
REQ-015 req_ready_o SHALL be 1 exactly in IDLE; at most one outstanding transfer.
REQ-016 IDLE & req_valid_i: capture addr/write/wdata/wstrb, go to SETUP next cycle.
REQ-017 SETUP: psel_o=1, penable_o=0, go to ACCESS unconditionally after one cycle.
REQ-018 ACCESS: psel_o=1, penable_o=1; stay while pready_i=0 and timeout not reached.
REQ-019 ACCESS & pready_i=1: capture prdata_i (reads) and pslverr_i, go to RESP; psel_o/penable_o low the following cycle.
REQ-020 paddr_o, pwrite_o, pwdata_o, pstrb_o SHALL hold captured values stable from SETUP through last ACCESS cycle.
REQ-021 pstrb_o SHALL be all-zero for reads; pwdata_o SHALL be zero for reads.
REQ-022 Timeout counter SHALL clear on SETUP entry, increment each ACCESS cycle with pready_i=0; on reaching TIMEOUT_CYCLES, go to RESP with rsp_error_o=1, rsp_rdata_o=0, psel_o/penable_o low next cycle.
REQ-023 pready_i arriving in same cycle counter reaches limit SHALL count as normal completion (pready wins).
REQ-024 RESP: rsp_valid_o=1, rsp_rdata_o/rsp_error_o stable until rsp_valid_o & rsp_ready_i, then IDLE.
REQ-025 rsp_rdata_o SHALL be 0 for writes; rsp_error_o = captured pslverr_i or timeout.
REQ-026 Minimum latency: accept at cycle N, SETUP N+1, ACCESS N+2, RESP N+3 (pready_i=1 in first ACCESS); next accept earliest N+4 if rsp_ready_i=1 at N+3.
REQ-027 pready_i, pslverr_i, prdata_i SHALL be ignored outside ACCESS.

Reset
REQ-028 rst_i high at a rising edge SHALL force IDLE, clear timeout counter and all captured registers to 0.
REQ-029 Reset values: req_ready_o=1 in first cycle after reset release, rsp_valid_o=0, rsp_error_o=0, rsp_rdata_o=0, psel_o=0, penable_o=0, paddr_o=0, pwrite_o=0, pwdata_o=0, pstrb_o=0, pprot_o=0.
REQ-030 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL abort without producing a response; psel_o=0 the cycle after the reset edge.

Verification
REQ-031 Write addr 0x0000_0010, wdata 0xDEAD_BEEF, wstrb 0xF, pready_i=1 immediately -> SETUP/ACCESS one cycle each, pstrb_o=0xF, rsp_valid_o at N+3, rsp_error_o=0, rsp_rdata_o=0.
REQ-032 Read addr 0x4, slave waits 3 cycles then pready_i=1, prdata_i=0x1234_5678 -> penable_o high 4 cycles, pstrb_o=0, rsp_rdata_o=0x1234_5678.
REQ-033 Read with pslverr_i=1 on pready cycle -> rsp_error_o=1; rsp held 5 cycles with rsp_ready_i=0, values stable, req_ready_o=0 throughout.
REQ-034 TIMEOUT_CYCLES=4, pready_i never asserted -> exactly 4 ACCESS cycles, then psel_o=0, rsp_error_o=1, rsp_rdata_o=0; repeat with pready_i=1 on 4th cycle -> rsp_error_o=0.
REQ-035 rst_i asserted during ACCESS -> psel_o=0, penable_o=0, rsp_valid_o=0 next cycle; no response emitted; new request after release completes normally.
REQ-036 Back-to-back requests with req_valid_i held high and rsp_ready_i=1 -> second accept exactly 4 cycles after first, second address appears only in its SETUP.

Source files
------------

// File: rtl/reg_to_apb_if.sv
// Bundles the request/response channel and the APB bus of the reg_to_apb bridge.
// The _i/_o suffixes are from the bridge's point of view: 'master' is the bridge, 'slave' is its environment.
interface reg_to_apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic                  req_write_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic [STRB_WIDTH-1:0] req_wstrb_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_error_o;

    logic [ADDR_WIDTH-1:0] paddr_o;
    logic                  pwrite_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [STRB_WIDTH-1:0] pstrb_o;
    logic [2:0]            pprot_o;
    logic                  psel_o;
    logic                  penable_o;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pready_i;
    logic                  pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i,
        output req_ready_o,
        input  rsp_ready_i,
        output rsp_valid_o, rsp_rdata_o, rsp_error_o,
        output paddr_o, pwrite_o, pwdata_o, pstrb_o, pprot_o, psel_o, penable_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i,
        input  req_ready_o,
        output rsp_ready_i,
        input  rsp_valid_o, rsp_rdata_o, rsp_error_o,
        input  paddr_o, pwrite_o, pwdata_o, pstrb_o, pprot_o, psel_o, penable_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/reg_to_apb.sv
// Single-outstanding bridge from a valid/ready register request channel to an APB master port.
// Every output is a register or a decode of the state register, so no input reaches an output combinationally.
module reg_to_apb #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk_i,
    input  logic          rst_i,
    reg_to_apb_if.master  bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    state_e                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic                  write_q,  write_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [STRB_WIDTH-1:0] strb_q,   strb_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic                  error_q,  error_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic                  timeoutHit;

    // The counter holds the number of completed stalled ACCESS cycles, so the
    // limit is hit on the TIMEOUT_CYCLES-th ACCESS cycle; pready still wins there.
    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        error_d = error_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    state_d = SETUP;
                    addr_d  = bus.req_addr_i;
                    write_d = bus.req_write_i;
                    wdata_d = bus.req_write_i ? bus.req_wdata_i : '0;
                    strb_d  = bus.req_write_i ? bus.req_wstrb_i : '0;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.pready_i) begin
                    state_d = RESP;
                    rdata_d = write_q ? '0 : bus.prdata_i;
                    error_d = bus.pslverr_i;
                end else if (timeoutHit) begin
                    state_d = RESP;
                    rdata_d = '0;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable_o   = (state_q == ACCESS);
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_error_o = error_q;
    assign bus.paddr_o     = addr_q;
    assign bus.pwrite_o    = write_q;
    assign bus.pwdata_o    = wdata_q;
    assign bus.pstrb_o     = strb_q;
    assign bus.pprot_o     = 3'b000;

    penableNeedsPsel: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.penable_o |-> bus.psel_o);

    readyOnlyWhenIdle: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.req_ready_o |-> (!bus.psel_o && !bus.rsp_valid_o));

    rspHeldUntilTaken: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.rsp_valid_o && !bus.rsp_ready_i) |=>
        (bus.rsp_valid_o && $stable(bus.rsp_rdata_o) && $stable(bus.rsp_error_o)));
endmodule

// File: tb/tb_reg_to_apb.sv
// Directed bench for reg_to_apb: a table of single transfers plus hand-written
// sequences for response back-pressure, mid-transfer reset and back-to-back requests.
module tb_reg_to_apb;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int TO    = 4;
    localparam int NEVER = 255;
    localparam int NVEC  = 8;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    reg_to_apb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    reg_to_apb #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        int            waitCycles;
        logic [DW-1:0] prdata;
        logic          slverr;
        int            holdCycles;
        logic [DW-1:0] expRdata;
        logic          expError;
        logic [SW-1:0] expStrb;
        logic [DW-1:0] expPwdata;
        int            expAccess;
    } vec_t;

    vec_t vecs [NVEC];
    int   testCount = 0;
    int   failCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idleInputs();
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_write_i = 1'b0;
        bus.req_wdata_i = '0;
        bus.req_wstrb_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;
    endtask

    // Runs one complete transfer starting from IDLE, playing the APB slave cycle by cycle.
    task automatic applyStimulus(input vec_t v, input string tag);
        int accessCount = 0;
        bit done = 0;

        checkOutput({tag, " req_ready idle"}, 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = v.addr;
        bus.req_write_i = v.write;
        bus.req_wdata_i = v.wdata;
        bus.req_wstrb_i = v.wstrb;
        stepCycle();

        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = 32'hBAD0_0000;
        bus.req_wdata_i = 32'hFFFF_FFFF;
        bus.req_wstrb_i = '1;
        bus.pready_i    = 1'b1;
        bus.pslverr_i   = 1'b1;
        bus.prdata_i    = 32'hFFFF_FFFF;
        checkOutput({tag, " setup psel"},    32'(bus.psel_o),      32'd1);
        checkOutput({tag, " setup penable"}, 32'(bus.penable_o),   32'd0);
        checkOutput({tag, " setup paddr"},   bus.paddr_o,          v.addr);
        checkOutput({tag, " setup pwrite"},  32'(bus.pwrite_o),    32'(v.write));
        checkOutput({tag, " setup pstrb"},   32'(bus.pstrb_o),     32'(v.expStrb));
        checkOutput({tag, " setup pwdata"},  bus.pwdata_o,         v.expPwdata);
        checkOutput({tag, " setup pprot"},   32'(bus.pprot_o),     32'd0);
        checkOutput({tag, " setup ready"},   32'(bus.req_ready_o), 32'd0);
        stepCycle();

        while (!done && accessCount < 40) begin
            if (bus.penable_o !== 1'b1 || bus.psel_o !== 1'b1) begin
                done = 1;
            end else begin
                accessCount++;
                checkOutput({tag, " access paddr"}, bus.paddr_o, v.addr);
                checkOutput({tag, " access pstrb"}, 32'(bus.pstrb_o), 32'(v.expStrb));
                if (accessCount == v.waitCycles + 1) begin
                    bus.pready_i  = 1'b1;
                    bus.prdata_i  = v.prdata;
                    bus.pslverr_i = v.slverr;
                end else begin
                    bus.pready_i  = 1'b0;
                    bus.prdata_i  = 32'h5A5A_5A5A;
                    bus.pslverr_i = 1'b1;
                end
                stepCycle();
            end
        end

        bus.pready_i  = 1'b1;
        bus.pslverr_i = 1'b1;
        bus.prdata_i  = 32'hC3C3_C3C3;
        checkOutput({tag, " access cycles"}, 32'(accessCount), 32'(v.expAccess));
        for (int h = 0; h <= v.holdCycles; h++) begin
            checkOutput({tag, " resp psel"},    32'(bus.psel_o),      32'd0);
            checkOutput({tag, " resp penable"}, 32'(bus.penable_o),   32'd0);
            checkOutput({tag, " rsp_valid"},    32'(bus.rsp_valid_o), 32'd1);
            checkOutput({tag, " rsp_rdata"},    bus.rsp_rdata_o,      v.expRdata);
            checkOutput({tag, " rsp_error"},    32'(bus.rsp_error_o), 32'(v.expError));
            checkOutput({tag, " resp ready"},   32'(bus.req_ready_o), 32'd0);
            if (h < v.holdCycles) stepCycle();
        end
        bus.rsp_ready_i = 1'b1;
        stepCycle();

        idleInputs();
        checkOutput({tag, " rsp_valid after"}, 32'(bus.rsp_valid_o), 32'd0);
        checkOutput({tag, " ready after"},     32'(bus.req_ready_o), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        //                w     addr            wdata           strb  wait   prdata          err   hold  expRdata        expErr expStrb expPwdata      acc
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0,     32'h9999_9999, 1'b0, 0, 32'h0000_0000, 1'b0, 4'hF, 32'hDEAD_BEEF, 1};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 3,     32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0, 4'h0, 32'h0000_0000, 4};
        vecs[2] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 0,     32'h7777_0001, 1'b1, 5, 32'h7777_0001, 1'b1, 4'h0, 32'h0000_0000, 1};
        vecs[3] = '{1'b0, 32'h0000_0080, 32'h0000_0000, 4'h0, NEVER, 32'hAAAA_AAAA, 1'b0, 0, 32'h0000_0000, 1'b1, 4'h0, 32'h0000_0000, 4};
        vecs[4] = '{1'b0, 32'h0000_0084, 32'h0000_0000, 4'h0, 3,     32'h0BAD_CAFE, 1'b0, 0, 32'h0BAD_CAFE, 1'b0, 4'h0, 32'h0000_0000, 4};
        vecs[5] = '{1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'h5, 1,     32'h1111_1111, 1'b1, 0, 32'h0000_0000, 1'b1, 4'h5, 32'hA5A5_0F0F, 2};
        vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_00FF, 4'h8, NEVER, 32'h2222_2222, 1'b0, 0, 32'h0000_0000, 1'b1, 4'h8, 32'h0000_00FF, 4};
        vecs[7] = '{1'b0, 32'h0000_000C, 32'h0000_0000, 4'h0, 2,     32'hFEDC_BA98, 1'b0, 0, 32'hFEDC_BA98, 1'b0, 4'h0, 32'h0000_0000, 3};

        idleInputs();
        rst_i = 1'b1;
        repeat (3) stepCycle();
        rst_i = 1'b0;

        checkOutput("reset req_ready", 32'(bus.req_ready_o), 32'd1);
        checkOutput("reset rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("reset rsp_error", 32'(bus.rsp_error_o), 32'd0);
        checkOutput("reset rsp_rdata", bus.rsp_rdata_o,      32'd0);
        checkOutput("reset psel",      32'(bus.psel_o),      32'd0);
        checkOutput("reset penable",   32'(bus.penable_o),   32'd0);
        checkOutput("reset paddr",     bus.paddr_o,          32'd0);
        checkOutput("reset pwrite",    32'(bus.pwrite_o),    32'd0);
        checkOutput("reset pwdata",    bus.pwdata_o,         32'd0);
        checkOutput("reset pstrb",     32'(bus.pstrb_o),     32'd0);
        checkOutput("reset pprot",     32'(bus.pprot_o),     32'd0);
        stepCycle();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while the slave is stalling: the transfer must vanish without a response.
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_0100;
        bus.req_write_i = 1'b0;
        stepCycle();
        idleInputs();
        stepCycle();
        stepCycle();
        checkOutput("midreset penable before", 32'(bus.penable_o), 32'd1);
        rst_i = 1'b1;
        stepCycle();
        rst_i = 1'b0;
        checkOutput("midreset psel",      32'(bus.psel_o),      32'd0);
        checkOutput("midreset penable",   32'(bus.penable_o),   32'd0);
        checkOutput("midreset rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("midreset req_ready", 32'(bus.req_ready_o), 32'd1);
        checkOutput("midreset paddr",     bus.paddr_o,          32'd0);
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            checkOutput("midreset no rsp", 32'(bus.rsp_valid_o), 32'd0);
        end
        applyStimulus(vecs[0], "postreset");

        // Back-to-back reads with the request and response sides always willing.
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_0200;
        bus.req_write_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        bus.pready_i    = 1'b1;
        bus.prdata_i    = 32'h1111_2222;
        checkOutput("b2b c0 ready", 32'(bus.req_ready_o), 32'd1);
        stepCycle();
        checkOutput("b2b c1 psel",  32'(bus.psel_o),      32'd1);
        checkOutput("b2b c1 paddr", bus.paddr_o,          32'h0000_0200);
        checkOutput("b2b c1 ready", 32'(bus.req_ready_o), 32'd0);
        bus.req_addr_i = 32'h0000_0300;
        stepCycle();
        checkOutput("b2b c2 penable", 32'(bus.penable_o), 32'd1);
        checkOutput("b2b c2 paddr",   bus.paddr_o,        32'h0000_0200);
        stepCycle();
        checkOutput("b2b c3 rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        checkOutput("b2b c3 rsp_rdata", bus.rsp_rdata_o,      32'h1111_2222);
        checkOutput("b2b c3 ready",     32'(bus.req_ready_o), 32'd0);
        bus.prdata_i = 32'h3333_4444;
        stepCycle();
        checkOutput("b2b c4 ready",     32'(bus.req_ready_o), 32'd1);
        checkOutput("b2b c4 rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("b2b c4 paddr",     bus.paddr_o,          32'h0000_0200);
        stepCycle();
        bus.req_valid_i = 1'b0;
        checkOutput("b2b c5 psel",  32'(bus.psel_o), 32'd1);
        checkOutput("b2b c5 paddr", bus.paddr_o,     32'h0000_0300);
        stepCycle();
        stepCycle();
        checkOutput("b2b c7 rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        checkOutput("b2b c7 rsp_rdata", bus.rsp_rdata_o,      32'h3333_4444);
        stepCycle();
        checkOutput("b2b c8 rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("b2b c8 ready",     32'(bus.req_ready_o), 32'd1);
        idleInputs();
        stepCycle();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
